// File: rtl/rf_pkg.sv
// Shared types and constants for the register-bank writeback arbiter.
package rf_pkg;

  typedef enum logic {
    ALU_PRI = 1'b0,
    LSU_PRI = 1'b1
  } wb_state_e;

  localparam int RF_ZERO_REG = 0;
  localparam int RF_NUM_REGS = 32;
  localparam int RF_DATA_WIDTH = 32;
  localparam int RF_ADDR_WIDTH = $clog2(RF_NUM_REGS);

  typedef struct packed {
    logic                     valid;
    logic [RF_ADDR_WIDTH-1:0] rd;
    logic [RF_DATA_WIDTH-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/wb_starve_counter.sv
// Saturating count of cycles the LSU has been held off the write port.
// o_tc flags that the count is at, or is stepping into, STARVE_LIMIT this cycle.
module wb_starve_counter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_tc
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT    = CW'(STARVE_LIMIT);
  localparam logic [CW-1:0] LIMIT_M1 = CW'(STARVE_LIMIT - 1);

  logic [CW-1:0] r_count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && (r_count != LIMIT)) begin
      r_count <= r_count + 1'b1;
    end
  end

  // Looking one step ahead lets the priority flip on the same edge the limit is reached.
  assign o_tc = !i_clr && ((r_count == LIMIT) || (i_inc && (r_count == LIMIT_M1)));

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Two-requester (ALU, LSU) arbiter for the register bank write port, with x0 sink and LSU starvation guard.
// Optional write-to-read forwarding ports are enabled by defining RF_WB_BYPASS_EN.
module regfile_wb_arbiter
  import rf_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 5,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  alu_valid,
  input  logic [ADDR_WIDTH-1:0] alu_rd,
  input  logic [DATA_WIDTH-1:0] alu_data,
  output logic                  alu_ready,
  input  logic                  lsu_valid,
  input  logic [ADDR_WIDTH-1:0] lsu_rd,
  input  logic [DATA_WIDTH-1:0] lsu_data,
  output logic                  lsu_ready,
`ifdef RF_WB_BYPASS_EN
  input  logic [ADDR_WIDTH-1:0] rs1_sel,
  input  logic [ADDR_WIDTH-1:0] rs2_sel,
  output logic                  rs1_fwd_valid,
  output logic                  rs2_fwd_valid,
  output logic [DATA_WIDTH-1:0] rs1_fwd_data,
  output logic [DATA_WIDTH-1:0] rs2_fwd_data,
`endif
  output logic                  reg_write,
  output logic [ADDR_WIDTH-1:0] rd_sel,
  output logic [DATA_WIDTH-1:0] write_data
);

  localparam logic [ADDR_WIDTH-1:0] ZERO_RD = ADDR_WIDTH'(RF_ZERO_REG);

  wb_state_e             r_state;
  logic                  r_reg_write;
  logic [ADDR_WIDTH-1:0] r_rd_sel;
  logic [DATA_WIDTH-1:0] r_write_data;

  logic w_alu_port;
  logic w_lsu_port;
  logic w_alu_sink;
  logic w_lsu_sink;
  logic w_alu_win;
  logic w_lsu_win;
  logic w_lsu_block;
  logic w_cnt_clr;
  logic w_cnt_tc;

  assign w_alu_port = alu_valid && (alu_rd != ZERO_RD);
  assign w_lsu_port = lsu_valid && (lsu_rd != ZERO_RD);
  assign w_alu_sink = alu_valid && (alu_rd == ZERO_RD);
  assign w_lsu_sink = lsu_valid && (lsu_rd == ZERO_RD);

  // A lone port request always wins; the state only breaks ties.
  assign w_lsu_win   = w_lsu_port && (!w_alu_port || (r_state == LSU_PRI));
  assign w_alu_win   = w_alu_port && !w_lsu_win;
  assign w_lsu_block = w_lsu_port && !w_lsu_win;

  assign alu_ready = !reset && (w_alu_sink || w_alu_win);
  assign lsu_ready = !reset && (w_lsu_sink || w_lsu_win);

  assign w_cnt_clr = !lsu_valid || lsu_ready;

  wb_starve_counter #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clock(clock),
    .reset(reset),
    .i_clr(w_cnt_clr),
    .i_inc(w_lsu_block),
    .o_tc (w_cnt_tc)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= ALU_PRI;
      r_reg_write  <= 1'b0;
      r_rd_sel     <= '0;
      r_write_data <= '0;
    end else begin
      case (r_state)
        ALU_PRI: if (w_cnt_tc) r_state <= LSU_PRI;
        LSU_PRI: if (w_lsu_win) r_state <= ALU_PRI;
        default: r_state <= ALU_PRI;
      endcase
      if (w_alu_win) begin
        r_reg_write  <= 1'b1;
        r_rd_sel     <= alu_rd;
        r_write_data <= alu_data;
      end else if (w_lsu_win) begin
        r_reg_write  <= 1'b1;
        r_rd_sel     <= lsu_rd;
        r_write_data <= lsu_data;
      end else begin
        r_reg_write  <= 1'b0;
      end
    end
  end

  assign reg_write  = r_reg_write;
  assign rd_sel     = r_rd_sel;
  assign write_data = r_write_data;

`ifdef RF_WB_BYPASS_EN
  // Forwarding covers the one cycle between our registered write and the bank commit.
  assign rs1_fwd_valid = r_reg_write && (r_rd_sel == rs1_sel) && (rs1_sel != ZERO_RD);
  assign rs2_fwd_valid = r_reg_write && (r_rd_sel == rs2_sel) && (rs2_sel != ZERO_RD);
  assign rs1_fwd_data  = r_write_data;
  assign rs2_fwd_data  = r_write_data;
`endif

endmodule
